// File: rtl/upacc_bridge.sv
// upacc_bridge: single-outstanding CPU access sequencer for the config-RAM port.
// Define UPACC_TIMEOUT_EN to add the WAIT timeout counter (htimeout path).
module upacc_bridge #(
    parameter int          ADDRBIT = 5,
    parameter int          WIDTH   = 32,
    parameter int          TOWIDTH = 8,
    parameter int          TOLIMIT = 255,
    parameter logic [31:0] TODATA  = 32'hDEADBEEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hreq,
    input  logic               hwr,
    input  logic [ADDRBIT-1:0] haddr,
    input  logic [WIDTH-1:0]   hwdata,
    output logic               hbusy,
    output logic               hack,
    output logic [WIDTH-1:0]   hrdata,
    output logic               htimeout,
    output logic               hreqdrop,
    output logic               upen,
    output logic [ADDRBIT-1:0] upa,
    output logic               upws,
    output logic               uprs,
    output logic [WIDTH-1:0]   updi,
    input  logic [WIDTH-1:0]   updo,
    input  logic               uprdy
);

    typedef enum logic [1:0] {IDLE, STRB, WAIT, DONE} state_t;

    state_t state;
    logic   hwr_lat;
    logic   to_fire;

`ifdef UPACC_TIMEOUT_EN
    logic [TOWIDTH-1:0] cnt;

    // Counts WAIT cycles only; held at zero everywhere else.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign to_fire = (state == WAIT) && (cnt == TOWIDTH'(TOLIMIT));
`else
    assign to_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hwr_lat  <= 1'b0;
            hbusy    <= 1'b0;
            hack     <= 1'b0;
            hrdata   <= '0;
            htimeout <= 1'b0;
            hreqdrop <= 1'b0;
            upen     <= 1'b0;
            upa      <= '0;
            upws     <= 1'b0;
            uprs     <= 1'b0;
            updi     <= '0;
        end else begin
            hack     <= 1'b0;
            htimeout <= 1'b0;
            hreqdrop <= hreq & hbusy;
            unique case (state)
                IDLE: begin
                    if (hreq) begin
                        state   <= STRB;
                        upa     <= haddr;
                        updi    <= hwdata;
                        hwr_lat <= hwr;
                        hbusy   <= 1'b1;
                        upen    <= 1'b1;
                        upws    <= hwr;
                        uprs    <= ~hwr;
                    end
                end
                STRB: begin
                    upws  <= 1'b0;
                    uprs  <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A ready in the firing cycle takes priority over timeout.
                    if (uprdy) begin
                        if (!hwr_lat)
                            hrdata <= updo;
                        upen  <= 1'b0;
                        hack  <= 1'b1;
                        state <= DONE;
                    end else if (to_fire) begin
                        if (!hwr_lat)
                            hrdata <= WIDTH'(TODATA);
                        htimeout <= 1'b1;
                        upen     <= 1'b0;
                        hack     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    hbusy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_upacc_bridge.sv
// Directed bench for upacc_bridge with a scoreboard of expected acknowledges.
// Timeout scenarios run only when UPACC_TIMEOUT_EN is defined.
module tb_upacc_bridge;

    localparam int TL = 4;

    logic        clk = 1'b0;
    logic        rst, hreq, hwr, uprdy;
    logic [4:0]  haddr, upa;
    logic [31:0] hwdata, hrdata, updi, updo;
    logic        hbusy, hack, htimeout, hreqdrop, upen, upws, uprs;

    typedef struct {
        logic [31:0] rdata;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_rdata;
    int          checks = 0;
    int          errors = 0;

    upacc_bridge #(
        .ADDRBIT(5), .WIDTH(32), .TOWIDTH(8), .TOLIMIT(TL), .TODATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .rst(rst), .hreq(hreq), .hwr(hwr), .haddr(haddr),
        .hwdata(hwdata), .hbusy(hbusy), .hack(hack), .hrdata(hrdata),
        .htimeout(htimeout), .hreqdrop(hreqdrop), .upen(upen), .upa(upa),
        .upws(upws), .uprs(uprs), .updi(updi), .updo(updo), .uprdy(uprdy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one access at c0 and follows it to hack.
    // rdy < 0 means the RAM never answers; drop is the cycle of an extra hreq.
    task automatic run_access(input string tag, input logic wr,
                              input logic [4:0] addr, input logic [31:0] wd,
                              input int rdy, input logic [31:0] rv,
                              input int drop);
        exp_t e;
        int   lat;
        bit   got;
        lat     = (rdy < 0) ? TL + 3 : rdy + 1;
        e.to    = (rdy < 0);
        e.rdata = wr ? last_rdata : ((rdy < 0) ? 32'hDEADBEEF : rv);
        last_rdata = e.rdata;
        sb.push_back(e);
        hreq = 1'b1; hwr = wr; haddr = addr; hwdata = wd;
        step();
        hreq = 1'b0; hwr = ~wr; haddr = ~addr; hwdata = ~wd;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            if (hack === 1'b1) begin
                got = 1'b1;
                chk({tag, " latency"}, k, lat);
                e = sb.pop_front();
                chk({tag, " hrdata"}, hrdata, e.rdata);
                chk({tag, " htimeout"}, htimeout, e.to);
                chk({tag, " upen@ack"}, upen, 1'b0);
                chk({tag, " hbusy@ack"}, hbusy, 1'b1);
            end else begin
                chk({tag, " upen"}, upen, 1'b1);
                chk({tag, " hbusy"}, hbusy, 1'b1);
                chk({tag, " upa"}, upa, addr);
                chk({tag, " updi"}, updi, wd);
                chk({tag, " upws"}, upws, (k == 1) && wr);
                chk({tag, " uprs"}, uprs, (k == 1) && !wr);
                chk({tag, " hreqdrop"}, hreqdrop, k == drop + 1);
                if (k == rdy) begin
                    uprdy = 1'b1;
                    updo  = rv;
                end
                if (k == drop) hreq = 1'b1;
                step();
                uprdy = 1'b0;
                updo  = $urandom;
                hreq  = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL %s ack: observed none expected hack by c%0d", tag, lat);
            sb.delete();
        end
        step();
        chk({tag, " hack after"}, hack, 1'b0);
        chk({tag, " hbusy after"}, hbusy, 1'b0);
        chk({tag, " hrdata held"}, hrdata, last_rdata);
    endtask

    initial begin
        rst = 1'b1; hreq = 1'b0; hwr = 1'b0; haddr = '0; hwdata = '0;
        uprdy = 1'b0; updo = '0; last_rdata = '0;
        step();
        step();
        chk("rst hbusy", hbusy, 1'b0);
        chk("rst hack", hack, 1'b0);
        chk("rst upen", upen, 1'b0);
        chk("rst strobes", {upws, uprs}, 2'b00);
        chk("rst upa", upa, 5'd0);
        chk("rst updi", updi, 32'd0);
        chk("rst hrdata", hrdata, 32'd0);
        chk("rst flags", {htimeout, hreqdrop}, 2'b00);
        rst = 1'b0;
        step();

        run_access("write", 1'b1, 5'h03, 32'hA5A5_0001, 5, 32'h0, -10);
        run_access("read", 1'b0, 5'h07, 32'h0, 4, 32'h1234_5678, -10);
        run_access("drop", 1'b1, 5'h01, 32'h0BAD_F00D, 4, 32'h0, 2);
        run_access("b2b", 1'b0, 5'h1F, 32'h0, 6, 32'h5555_AAAA, -10);

        hreq = 1'b1; hwr = 1'b0; haddr = 5'h09;
        step();
        hreq = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_rdata = '0;
        chk("midrst upen", upen, 1'b0);
        chk("midrst hbusy", hbusy, 1'b0);
        chk("midrst hack", hack, 1'b0);
        chk("midrst hrdata", hrdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            uprdy = (i == 1);
            updo  = 32'hFFFF_0000;
            step();
            uprdy = 1'b0;
            chk("midrst no hack", hack, 1'b0);
            chk("midrst idle upen", upen, 1'b0);
        end
        run_access("post-rst", 1'b0, 5'h0A, 32'h0, 4, 32'h0F0F_1234, -10);

`ifdef UPACC_TIMEOUT_EN
        run_access("timeout", 1'b0, 5'h04, 32'h0, -1, 32'h0, -10);
        run_access("race", 1'b0, 5'h05, 32'h0, TL + 2, 32'hCAFE_0001, -10);
        run_access("wr-to", 1'b1, 5'h06, 32'h7777_0000, -1, 32'h0, -10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/upacc_bridge.md
Name: upacc_bridge

Overview:
- Single-outstanding CPU access sequencer. Sits directly upstream of the config-RAM CPU port (upen/upa/upws/uprs/updi/updo/uprdy).
- Converts a one-cycle host request into the strobe/enable sequence that port requires: strobe for one cycle, enable and address/data held until ready.
- Captures read data and returns a one-cycle acknowledge, with optional timeout.

Parameters:
- ADDRBIT, 5, address width to RAM port
- WIDTH, 32, data width
- TOWIDTH, 8, timeout counter width
- TOLIMIT, 255, WAIT cycles before timeout (1..2^TOWIDTH-1)
- TODATA, 32'hDEADBEEF, read data returned on timeout (truncated to WIDTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- hreq  in  1  request pulse, sampled only when hbusy=0
- hwr  in  1  1=write, 0=read, qualified by hreq
- haddr  in  ADDRBIT  request address
- hwdata  in  WIDTH  write data
- hbusy  out  1  access in progress
- hack  out  1  one-cycle completion pulse
- hrdata  out  WIDTH  read data, valid with hack, held until next hack
- htimeout  out  1  qualifies hack: access timed out
- hreqdrop  out  1  one-cycle pulse: hreq seen while hbusy=1 (request ignored)
- upen  out  1  CPU enable to RAM port
- upa  out  ADDRBIT  RAM address
- upws  out  1  write strobe
- uprs  out  1  read strobe
- updi  out  WIDTH  write data
- updo  in  WIDTH  read data from RAM port, valid when uprdy=1
- uprdy  in  1  ready pulse from RAM port

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE. All outputs 0: hbusy, hack, htimeout, hreqdrop, upen, upws, uprs, upa, updi, hrdata, timeout counter.
- Reset mid-access: abandon the access, upen drops the next cycle, no hack issued.
- All outputs are registered.
- FSM state IDLE: hbusy=0.
  - hreq=1: latch haddr→upa, hwdata→updi, hwr → go STRB.
- FSM state STRB: upen=1, hbusy=1, for exactly one cycle.
  - upws=hwr_lat, uprs=~hwr_lat.
  - → WAIT.
- FSM state WAIT: upen=1, strobes=0, upa/updi held stable, counter increments each cycle.
  - uprdy=1: hrdata←updo (reads only; writes leave hrdata unchanged) → DONE.
  - Timeout fires (see Optional Feature): htimeout_lat=1, hrdata←TODATA (reads only) → DONE.
- FSM state DONE: upen=0, hack=1 for one cycle, htimeout=htimeout_lat, counter cleared → IDLE.
  - hbusy=1 in DONE; hbusy falls in IDLE.
- uprdy outside WAIT is ignored.
- uprdy in the same cycle the timeout would fire: uprdy wins, htimeout=0.
- hreq while hbusy=1: request ignored, hreqdrop=1 next cycle.
- hreq in IDLE is accepted even in the cycle directly after DONE. Back-to-back issue gap is therefore 1 cycle.
- upen low between accesses guarantees the RAM port clears any pending read latch.
- Nominal latency (hreq cycle=0, RAM port idle):
  - write: STRB c1, uprdy c5, hack c6.
  - read: STRB c1, uprdy c4, hack c5.
  - Engine contention at the RAM extends WAIT; the bridge only requires uprdy eventually.

Optional Feature:
- Macro: UPACC_TIMEOUT_EN.
- Defined: WAIT counter of TOWIDTH bits. When the counter equals TOLIMIT without uprdy, the timeout path is taken. htimeout is driven by that path.
- Undefined: no counter. WAIT holds indefinitely until uprdy or rst. htimeout is tied 0.

Test Plan:
- Write: reset, hreq hwr=1 haddr=5'h03 hwdata=32'hA5A5_0001; RAM model uprdy at c5 → upws=1 only at c1; upen=1 c1–c5, 0 at c6; upa=3 and updi stable c1–c5; hack=1 at c6; htimeout=0.
- Read: RAM model returns updo=32'h1234_5678 with uprdy at c4 → uprs=1 only at c1; hack at c5; hrdata=32'h1234_5678, held after hack.
- Busy drop: hreq at c0 and again at c2 → second request ignored, hreqdrop=1 at c3; only one strobe issued.
- Timeout (UPACC_TIMEOUT_EN, TOLIMIT=4): read with uprdy never asserted → hack with htimeout=1; hrdata=32'hDEADBEEF; upen=0 in the hack cycle.
- Timeout race (UPACC_TIMEOUT_EN, TOLIMIT=4): uprdy asserted in the cycle the timeout would fire → htimeout=0, hrdata=updo.
- Reset mid-access: rst=1 during WAIT → next cycle upen=0, hbusy=0, no hack. A new hreq after reset completes normally.
